// File: rtl/gpio_loader_pkg.sv
// Purpose : shared types and constants for the GPIO configuration-chain loader.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum, bit offsets of the fields inside one pad control
// word, default word width, and an index-width helper.
package gpio_loader_pkg;

    localparam int PAD_CTRL_BITS_DEF = 13;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        LOAD,
        DONE
    } loader_state_e;

    // Field offsets inside one control block's shift register.
    localparam int MGMT_EN = 0;
    localparam int OEB     = 1;
    localparam int HLDH    = 2;
    localparam int INP_DIS = 3;
    localparam int MOD_SEL = 4;
    localparam int AN_EN   = 5;
    localparam int AN_SEL  = 6;
    localparam int AN_POL  = 7;
    localparam int SLOW    = 8;
    localparam int TRIP    = 9;
    localparam int DM_LSB  = 10;
    localparam int DM_MSB  = 12;

    // Width of an index over n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpio_serial_loader_if.sv
// Purpose : start/status handshake and register-file read port of the loader.
// Latency : cfg_word is expected one clock after cfg_idx changes.
// Backpressure: none; xfer_start is a pulse that is dropped while busy.
//
// Signals: xfer_start (host->loader), busy/done (loader->host),
//          cfg_idx (loader->regfile), cfg_word (regfile->loader).
// Modports: master = host/register-file side, slave = loader side.
interface gpio_serial_loader_if import gpio_loader_pkg::*; #(
    parameter int NUM_GPIO      = 19,
    parameter int PAD_CTRL_BITS = PAD_CTRL_BITS_DEF
);
    localparam int IDXW = idx_width(NUM_GPIO);

    logic                     xfer_start;
    logic                     busy;
    logic                     done;
    logic [IDXW-1:0]          cfg_idx;
    logic [PAD_CTRL_BITS-1:0] cfg_word;

    modport master (
        output xfer_start,
        output cfg_word,
        input  busy,
        input  done,
        input  cfg_idx
    );

    modport slave (
        input  xfer_start,
        input  cfg_word,
        output busy,
        output done,
        output cfg_idx
    );

endinterface

// File: rtl/gpio_loader_clkdiv.sv
// Purpose : half-period tick generator for the chain shift clock.
// Latency : first tick HALF clocks after restart_i deasserts, then every HALF clocks.
// Backpressure: none; restart_i holds the counter at zero and masks the tick.
//
// Ports: clk_i, rst_n_i (async active-low), restart_i, tick_o.
module gpio_loader_clkdiv #(
    parameter int HALF = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic restart_i,
    output logic tick_o
);
    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = !restart_i && (cnt_q == LAST);

endmodule

// File: rtl/gpio_serial_loader.sv
// Purpose : fetches one config word per GPIO and shifts them into the pad-control
//           daisy chain (farthest GPIO first, MSB first), then strobes serial_load.
// Latency : NUM_GPIO*(2 + CLK_DIV*PAD_CTRL_BITS) + 2*CLK_DIV clocks from start to done.
// Backpressure: none; xfer_start is ignored while busy or in the done cycle.
//
// Ports: clock, resetn (async active-low), cfg_if (slave: xfer_start, busy, done,
//        cfg_idx, cfg_word), serial_clock, serial_data_out, serial_load.
// Optional GPIO_LOADER_BITBANG_EN adds bb_en/bb_clock/bb_data/bb_load: while idle
// with bb_en high the serial outputs are registered copies of the bb_* inputs.
module gpio_serial_loader import gpio_loader_pkg::*; #(
    parameter int NUM_GPIO      = 19,
    parameter int PAD_CTRL_BITS = PAD_CTRL_BITS_DEF,
    parameter int CLK_DIV       = 4
) (
    input  logic                 clock,
    input  logic                 resetn,
    gpio_serial_loader_if.slave  cfg_if,
`ifdef GPIO_LOADER_BITBANG_EN
    input  logic                 bb_en,
    input  logic                 bb_clock,
    input  logic                 bb_data,
    input  logic                 bb_load,
`endif
    output logic                 serial_clock,
    output logic                 serial_data_out,
    output logic                 serial_load
);
    localparam int IDXW = idx_width(NUM_GPIO);
    localparam int BW   = idx_width(PAD_CTRL_BITS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_GPIO - 1);
    localparam logic [BW-1:0]   MSB_BIT  = BW'(PAD_CTRL_BITS - 1);

    loader_state_e            state_q;
    logic [IDXW-1:0]          cfg_idx_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     sclk_q;
    logic                     sdo_q;
    logic                     sload_q;
    logic [PAD_CTRL_BITS-1:0] word_q;
    logic [BW-1:0]            bit_cnt_q;
    logic                     fetch_2nd_q;
    logic [1:0]               load_ph_q;

    logic tick;
    logic div_restart;
    logic start_ok;

    // The divider runs only in SHIFT/LOAD; entering LOAD coincides with a tick,
    // where the counter wraps to zero, so both states start on a fresh half-period.
    assign div_restart = !((state_q == SHIFT) || (state_q == LOAD));

    gpio_loader_clkdiv #(
        .HALF (CLK_DIV / 2)
    ) u_clkdiv (
        .clk_i     (clock),
        .rst_n_i   (resetn),
        .restart_i (div_restart),
        .tick_o    (tick)
    );

`ifdef GPIO_LOADER_BITBANG_EN
    assign start_ok = cfg_if.xfer_start && !bb_en;
`else
    assign start_ok = cfg_if.xfer_start;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cfg_idx_q   <= LAST_IDX;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sclk_q      <= 1'b0;
            sdo_q       <= 1'b0;
            sload_q     <= 1'b0;
            word_q      <= '0;
            bit_cnt_q   <= '0;
            fetch_2nd_q <= 1'b0;
            load_ph_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
`ifdef GPIO_LOADER_BITBANG_EN
                    sclk_q  <= bb_en & bb_clock;
                    sdo_q   <= bb_en & bb_data;
                    sload_q <= bb_en & bb_load;
`endif
                    if (start_ok) begin
                        cfg_idx_q   <= LAST_IDX;
                        busy_q      <= 1'b1;
                        fetch_2nd_q <= 1'b0;
                        state_q     <= FETCH;
                    end
                end

                // First clock lets the register file see cfg_idx; second samples the word.
                FETCH: begin
                    sclk_q <= 1'b0;
                    if (!fetch_2nd_q) begin
                        fetch_2nd_q <= 1'b1;
                    end else begin
                        word_q    <= cfg_if.cfg_word;
                        sdo_q     <= cfg_if.cfg_word[PAD_CTRL_BITS-1];
                        bit_cnt_q <= MSB_BIT;
                        state_q   <= SHIFT;
                    end
                end

                // Data only moves on the falling tick, so it is stable across each rise.
                SHIFT: begin
                    if (tick) begin
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else begin
                            sclk_q <= 1'b0;
                            if (bit_cnt_q == '0) begin
                                if (cfg_idx_q == '0) begin
                                    sload_q   <= 1'b1;
                                    load_ph_q <= '0;
                                    state_q   <= LOAD;
                                end else begin
                                    cfg_idx_q   <= cfg_idx_q - 1'b1;
                                    fetch_2nd_q <= 1'b0;
                                    state_q     <= FETCH;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q - 1'b1;
                                sdo_q     <= word_q[bit_cnt_q - 1'b1];
                            end
                        end
                    end
                end

                // Four half-periods: strobe high for two, low for two.
                LOAD: begin
                    if (tick) begin
                        load_ph_q <= load_ph_q + 1'b1;
                        if (load_ph_q == 2'd1) begin
                            sload_q <= 1'b0;
                        end
                        if (load_ph_q == 2'd3) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            sdo_q   <= 1'b0;
                            state_q <= DONE;
                        end
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cfg_if.busy     = busy_q;
    assign cfg_if.done     = done_q;
    assign cfg_if.cfg_idx  = cfg_idx_q;
    assign serial_clock    = sclk_q;
    assign serial_data_out = sdo_q;
    assign serial_load     = sload_q;

endmodule

// File: tb/tb_gpio_serial_loader.sv
`timescale 1ns/1ps
module tb_gpio_serial_loader;
    import gpio_loader_pkg::*;

    localparam int P  = 13;
    localparam int NA = 2;
    localparam int DA = 4;
    localparam int NB = 19;
    localparam int DB = 2;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    gpio_serial_loader_if #(.NUM_GPIO(NA), .PAD_CTRL_BITS(P)) if_a ();
    gpio_serial_loader_if #(.NUM_GPIO(NB), .PAD_CTRL_BITS(P)) if_b ();

    logic sclk_a, sdo_a, sld_a, sclk_b, sdo_b, sld_b;
`ifdef GPIO_LOADER_BITBANG_EN
    logic bb_en_a, bb_clk_a, bb_dat_a, bb_ld_a;
`endif

    gpio_serial_loader #(.NUM_GPIO(NA), .PAD_CTRL_BITS(P), .CLK_DIV(DA)) dut_a (
        .clock(clock), .resetn(resetn), .cfg_if(if_a),
`ifdef GPIO_LOADER_BITBANG_EN
        .bb_en(bb_en_a), .bb_clock(bb_clk_a), .bb_data(bb_dat_a), .bb_load(bb_ld_a),
`endif
        .serial_clock(sclk_a), .serial_data_out(sdo_a), .serial_load(sld_a)
    );

    gpio_serial_loader #(.NUM_GPIO(NB), .PAD_CTRL_BITS(P), .CLK_DIV(DB)) dut_b (
        .clock(clock), .resetn(resetn), .cfg_if(if_b),
`ifdef GPIO_LOADER_BITBANG_EN
        .bb_en(1'b0), .bb_clock(1'b0), .bb_data(1'b0), .bb_load(1'b0),
`endif
        .serial_clock(sclk_b), .serial_data_out(sdo_b), .serial_load(sld_b)
    );

    // Register file: synchronous read, word appears one clock after the index.
    logic [P-1:0] words_a [NA];
    logic [P-1:0] words_b [NB];
    always @(posedge clock) begin
        if_a.cfg_word <= words_a[if_a.cfg_idx];
        if_b.cfg_word <= words_b[if_b.cfg_idx];
    end

    // Chain models: shift on serial_clock rise, retime block output on fall, latch on load.
    logic [P-1:0] sr_a [NA];
    logic [P-1:0] lat_a [NA];
    logic         rt_a [NA];
    logic [P-1:0] sr_b [NB];
    logic [P-1:0] lat_b [NB];
    logic         rt_b [NB];
    int rise_a = 0, rise_b = 0, load_evt_a = 0, load_evt_b = 0;
    int load_clk_a = 0, done_a = 0, done_b = 0, busy_cyc_b = 0;

    always @(posedge sclk_a) begin
        sr_a[0] <= {sr_a[0][P-2:0], sdo_a};
        for (int i = 1; i < NA; i++) sr_a[i] <= {sr_a[i][P-2:0], rt_a[i-1]};
        rise_a++;
    end
    always @(negedge sclk_a) for (int i = 0; i < NA; i++) rt_a[i] <= sr_a[i][P-1];
    always @(posedge sld_a) begin
        for (int i = 0; i < NA; i++) lat_a[i] <= sr_a[i];
        load_evt_a++;
    end

    always @(posedge sclk_b) begin
        sr_b[0] <= {sr_b[0][P-2:0], sdo_b};
        for (int i = 1; i < NB; i++) sr_b[i] <= {sr_b[i][P-2:0], rt_b[i-1]};
        rise_b++;
    end
    always @(negedge sclk_b) for (int i = 0; i < NB; i++) rt_b[i] <= sr_b[i][P-1];
    always @(posedge sld_b) begin
        for (int i = 0; i < NB; i++) lat_b[i] <= sr_b[i];
        load_evt_b++;
    end

    always @(negedge clock) begin
        if (sld_a) load_clk_a++;
        if (if_a.done) done_a++;
        if (if_b.done) done_b++;
        if (if_b.busy) busy_cyc_b++;
    end

    // Scoreboard of expected latched words per block.
    typedef struct { int dut; int blk; logic [P-1:0] w; } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [P-1:0] w1;
        logic [P-1:0] w0;
        int           exp_rises;
        int           exp_load_clks;
    } vec_t;
    vec_t vecs[4];

    int n_cmp = 0;
    int n_fail = 0;
    logic sclk_prev = 1'b0;
    logic sdo_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance to the next falling clock edge and check serial data stability on dut_a.
    task automatic step();
        @(negedge clock);
        if (!sclk_prev && sclk_a === 1'b1) chk("sdo_stable_at_rise", sdo_a, sdo_prev);
        else if (sclk_prev && sclk_a === 1'b1) chk("sdo_hold_while_high", sdo_a, sdo_prev);
        sclk_prev = sclk_a;
        sdo_prev  = sdo_a;
    endtask

    task automatic wait_done(input int which, input int budget, input string tag);
        int n;
        logic d;
        n = 0;
        d = (which == 0) ? if_a.done : if_b.done;
        while (d !== 1'b1 && n < budget) begin
            step();
            n++;
            d = (which == 0) ? if_a.done : if_b.done;
        end
        chk({tag, "_done_seen"}, 32'(d === 1'b1), 1);
    endtask

    task automatic check_sb();
        sb_t e;
        logic [P-1:0] got;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.dut == 0) got = lat_a[e.blk];
            else            got = lat_b[e.blk];
            chk($sformatf("latch_dut%0d_blk%0d", e.dut, e.blk), got, e.w);
        end
    endtask

    task automatic start_a();
        if_a.xfer_start = 1'b1;
        step();
        if_a.xfer_start = 1'b0;
    endtask

    task automatic xfer_a(input logic [P-1:0] w1, input logic [P-1:0] w0,
                          input int exp_rises, input int exp_lclk, input string tag);
        int br, bl, bd, be;
        words_a[1] = w1;
        words_a[0] = w0;
        sb.push_back('{dut: 0, blk: 1, w: w1});
        sb.push_back('{dut: 0, blk: 0, w: w0});
        br = rise_a; bl = load_clk_a; bd = done_a; be = load_evt_a;
        start_a();
        chk({tag, "_busy_after_start"}, if_a.busy, 1);
        wait_done(0, 400, tag);
        chk({tag, "_busy_low_at_done"}, if_a.busy, 0);
        repeat (4) step();
        chk({tag, "_rises"}, rise_a - br, exp_rises);
        chk({tag, "_load_clks"}, load_clk_a - bl, exp_lclk);
        chk({tag, "_load_pulses"}, load_evt_a - be, 1);
        chk({tag, "_done_pulses"}, done_a - bd, 1);
        check_sb();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int br, bd, be, bb, n;
        logic [P-1:0] w, bbw;

        vecs[0] = '{w1: 13'h1A5B, w0: 13'h0403, exp_rises: 26, exp_load_clks: 4};
        vecs[1] = '{w1: 13'h1FFF, w0: 13'h0000, exp_rises: 26, exp_load_clks: 4};
        vecs[2] = '{w1: 13'h0000, w0: 13'h1FFF, exp_rises: 26, exp_load_clks: 4};
        vecs[3] = '{w1: 13'h1555, w0: 13'h0AAA, exp_rises: 26, exp_load_clks: 4};

        resetn = 1'b0;
        if_a.xfer_start = 1'b0;
        if_b.xfer_start = 1'b0;
        for (int i = 0; i < NA; i++) words_a[i] = '0;
        for (int i = 0; i < NB; i++) words_b[i] = '0;
`ifdef GPIO_LOADER_BITBANG_EN
        bb_en_a = 1'b0; bb_clk_a = 1'b0; bb_dat_a = 1'b0; bb_ld_a = 1'b0;
`endif
        repeat (2) step();
        chk("rst_busy", if_a.busy, 0);
        chk("rst_done", if_a.done, 0);
        chk("rst_cfg_idx_a", if_a.cfg_idx, NA - 1);
        chk("rst_cfg_idx_b", if_b.cfg_idx, NB - 1);
        chk("rst_sclk", sclk_a, 0);
        chk("rst_sdo", sdo_a, 0);
        chk("rst_sload", sld_a, 0);
        resetn = 1'b1;
        repeat (2) step();

        // Table-driven full-chain transfers on the two-block chain.
        for (int v = 0; v < 4; v++)
            xfer_a(vecs[v].w1, vecs[v].w0, vecs[v].exp_rises, vecs[v].exp_load_clks,
                   $sformatf("vec%0d", v));

        // Start pulses mid-SHIFT and in the DONE cycle must be ignored.
        words_a[1] = 13'h0F0F;
        words_a[0] = 13'h10F0;
        sb.push_back('{dut: 0, blk: 1, w: 13'h0F0F});
        sb.push_back('{dut: 0, blk: 0, w: 13'h10F0});
        br = rise_a; bd = done_a; be = load_evt_a;
        start_a();
        n = 0;
        while (rise_a - br < 5 && n < 200) begin step(); n++; end
        chk("t3_reached_shift", 32'(n < 200), 1);
        start_a();
        wait_done(0, 400, "t3");
        start_a();
        repeat (150) step();
        chk("t3_rises", rise_a - br, 26);
        chk("t3_done_pulses", done_a - bd, 1);
        chk("t3_load_pulses", load_evt_a - be, 1);
        chk("t3_idle_after", if_a.busy, 0);
        check_sb();

        // Reset after 10 rising edges: everything returns to reset values at once.
        words_a[1] = 13'h0ABC;
        words_a[0] = 13'h1357;
        br = rise_a; be = load_evt_a;
        start_a();
        n = 0;
        while (rise_a - br < 10 && n < 200) begin step(); n++; end
        chk("t4_ten_rises", rise_a - br, 10);
        resetn = 1'b0;
        #1;
        chk("t4_rst_busy", if_a.busy, 0);
        chk("t4_rst_done", if_a.done, 0);
        chk("t4_rst_sclk", sclk_a, 0);
        chk("t4_rst_sdo", sdo_a, 0);
        chk("t4_rst_sload", sld_a, 0);
        chk("t4_rst_cfg_idx", if_a.cfg_idx, NA - 1);
        step();
        step();
        resetn = 1'b1;
        repeat (2) step();
        chk("t4_no_load", load_evt_a - be, 0);
        xfer_a(13'h1A5B, 13'h0403, 26, 4, "t4_reload");

        // Full 19-block chain at the fastest divider.
        for (int pass = 0; pass < 2; pass++) begin
            w = (pass == 0) ? 13'h1FFF : 13'h0000;
            for (int i = 0; i < NB; i++) begin
                words_b[i] = w;
                sb.push_back('{dut: 1, blk: i, w: w});
            end
            br = rise_b; bb = busy_cyc_b; bd = done_b; be = load_evt_b;
            if_b.xfer_start = 1'b1;
            step();
            if_b.xfer_start = 1'b0;
            wait_done(1, 2000, $sformatf("t5p%0d", pass));
            repeat (4) step();
            chk($sformatf("t5p%0d_rises", pass), rise_b - br, NB * P);
            chk($sformatf("t5p%0d_busy_cycles", pass), busy_cyc_b - bb, NB * (2 + DB * P) + 2 * DB);
            chk($sformatf("t5p%0d_done_pulses", pass), done_b - bd, 1);
            chk($sformatf("t5p%0d_load_pulses", pass), load_evt_b - be, 1);
            check_sb();
        end

`ifdef GPIO_LOADER_BITBANG_EN
        // Bit-bang one word into block 0 while xfer_start is locked out.
        bbw = '0;
        bbw[MGMT_EN] = 1'b1;
        bbw[AN_POL]  = 1'b1;
        bbw[SLOW]    = 1'b1;
        bbw[DM_LSB]  = 1'b1;
        bbw[DM_MSB]  = 1'b1;
        bb_en_a = 1'b1;
        step();
        br = rise_a; be = load_evt_a;
        start_a();
        step();
        chk("bb_start_blocked", if_a.busy, 0);
        for (int i = P - 1; i >= 0; i--) begin
            bb_dat_a = bbw[i];
            step(); step();
            bb_clk_a = 1'b1;
            step(); step();
            bb_clk_a = 1'b0;
            step();
        end
        bb_ld_a = 1'b1;
        step(); step();
        bb_ld_a = 1'b0;
        step(); step();
        chk("bb_rises", rise_a - br, P);
        chk("bb_load_pulses", load_evt_a - be, 1);
        sb.push_back('{dut: 0, blk: 0, w: bbw});
        check_sb();
        bb_en_a = 1'b0;
        repeat (2) step();
        chk("bb_release_sclk", sclk_a, 0);
`else
        bbw = '0;
        w = bbw;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
